mem_arbiter: RTL and testbench

Two-port main-memory arbiter that shares the single backing-memory port between instruction-cache and data-cache miss traffic. It sits below both caches and carries line refills for both. For the data cache it also carries line write-backs. It runs one transaction at a time, uses round-robin grant, counts beats, and routes each response beat back to the requester that owns the transaction.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between icache
// refills and dcache refills/write-backs, one transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  ic_req_valid,
    output logic                  ic_req_ready,
    input  logic [ADDR_W-1:0]     ic_req_addr,
    output logic                  ic_resp_valid,
    output logic [DATA_W-1:0]     ic_resp_data,

    input  logic                  dc_req_valid,
    output logic                  dc_req_ready,
    input  logic                  dc_req_rw,
    input  logic [ADDR_W-1:0]     dc_req_addr,
    input  logic                  dc_wdata_valid,
    output logic                  dc_wdata_ready,
    input  logic [DATA_W-1:0]     dc_wdata,
    input  logic [DATA_W/8-1:0]   dc_wdata_mask,
    output logic                  dc_resp_valid,
    output logic [DATA_W-1:0]     dc_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wdata_mask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,

    output logic                  busy,
    output logic                  owner
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             last_grant;
    logic [CNT_W-1:0] beat_cnt;

    logic in_idle;
    logic in_req;
    logic in_wdata;
    logic in_resp;
    logic any_req;
    logic grant_dc;
    logic req_fire;
    logic wr_fire;
    logic rd_fire;
    logic beat_fire;
    logic last_beat;

    assign in_idle  = (state == S_IDLE);
    assign in_req   = (state == S_REQ);
    assign in_wdata = (state == S_WDATA);
    assign in_resp  = (state == S_RESP);

    assign any_req  = ic_req_valid | dc_req_valid;

    // Pick the dcache alone, or on a tie whoever was not granted last
    always_comb begin
        grant_dc = dc_req_valid;
        if (ic_req_valid && dc_req_valid)
            grant_dc = ~last_grant;
    end

    assign req_fire  = mem_req_valid & mem_req_ready;
    assign wr_fire   = mem_wdata_valid & mem_wdata_ready;
    assign rd_fire   = in_resp & mem_resp_valid;
    assign beat_fire = wr_fire | rd_fire;
    assign last_beat = (beat_cnt == LAST);

    // Transaction sequencing; the final beat always lands back in IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (any_req)
                    state_nx = S_REQ;
            end
            S_REQ: begin
                if (req_fire)
                    state_nx = mem_req_rw ? S_WDATA : S_RESP;
            end
            S_WDATA: begin
                if (wr_fire && last_beat)
                    state_nx = S_IDLE;
            end
            S_RESP: begin
                if (rd_fire && last_beat)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Grant is registered in IDLE; last_grant starts at icache so dcache wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b0;
        end else if (in_idle && any_req) begin
            owner      <= grant_dc;
            last_grant <= grant_dc;
        end
    end

    // Beat counter, cleared on grant and wrapped on the final beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            beat_cnt <= '0;
        else if (in_idle && any_req)
            beat_cnt <= '0;
        else if (beat_fire)
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end

    assign mem_req_valid  = in_req & (owner ? dc_req_valid : ic_req_valid);
    assign mem_req_rw     = owner & dc_req_rw;
    assign mem_req_addr   = owner ? dc_req_addr : ic_req_addr;
    assign ic_req_ready   = in_req & ~owner & mem_req_ready;
    assign dc_req_ready   = in_req & owner & mem_req_ready;

    assign mem_wdata_valid = in_wdata & dc_wdata_valid;
    assign dc_wdata_ready  = in_wdata & mem_wdata_ready;
    assign mem_wdata       = dc_wdata;
    assign mem_wdata_mask  = dc_wdata_mask;

    assign ic_resp_valid = rd_fire & ~owner;
    assign dc_resp_valid = rd_fire & owner;
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;

    assign busy = ~in_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, round-robin ties, write-back,
// backpressure, stray/gapped beats and mid-transaction reset.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ic_req_valid;
    logic            ic_req_ready;
    logic [AW-1:0]   ic_req_addr;
    logic            ic_resp_valid;
    logic [DW-1:0]   ic_resp_data;
    logic            dc_req_valid;
    logic            dc_req_ready;
    logic            dc_req_rw;
    logic [AW-1:0]   dc_req_addr;
    logic            dc_wdata_valid;
    logic            dc_wdata_ready;
    logic [DW-1:0]   dc_wdata;
    logic [DW/8-1:0] dc_wdata_mask;
    logic            dc_resp_valid;
    logic [DW-1:0]   dc_resp_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_rw;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_wdata_valid;
    logic            mem_wdata_ready;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wdata_mask;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_resp_data;
    logic            busy;
    logic            owner;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ic_req_valid    (ic_req_valid),
        .ic_req_ready    (ic_req_ready),
        .ic_req_addr     (ic_req_addr),
        .ic_resp_valid   (ic_resp_valid),
        .ic_resp_data    (ic_resp_data),
        .dc_req_valid    (dc_req_valid),
        .dc_req_ready    (dc_req_ready),
        .dc_req_rw       (dc_req_rw),
        .dc_req_addr     (dc_req_addr),
        .dc_wdata_valid  (dc_wdata_valid),
        .dc_wdata_ready  (dc_wdata_ready),
        .dc_wdata        (dc_wdata),
        .dc_wdata_mask   (dc_wdata_mask),
        .dc_resp_valid   (dc_resp_valid),
        .dc_resp_data    (dc_resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_wdata       (mem_wdata),
        .mem_wdata_mask  (mem_wdata_mask),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .busy            (busy),
        .owner           (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns 2 time units after a rising edge; inputs are driven then
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic read_beats(input logic to_dc, input int gap, input logic [127:0] base);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                mem_resp_valid = 1'b0;
                #1;
                chk("gap_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
                cyc();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 128'(i);
            #1;
            chk("resp_own", to_dc ? dc_resp_valid : ic_resp_valid, 1'b1);
            chk("resp_other", to_dc ? ic_resp_valid : dc_resp_valid, 1'b0);
            chk("resp_data", to_dc ? dc_resp_data : ic_resp_data, base + 128'(i));
            cyc();
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        reset_n = 1'b0;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
        dc_wdata_valid = 0; dc_wdata = '0; dc_wdata_mask = '0;
        mem_req_ready = 0; mem_wdata_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
        cyc(); cyc();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_mreq", mem_req_valid, 1'b0);
        reset_n = 1'b1;
        cyc();

        // Single icache read
        ic_req_valid = 1; ic_req_addr = 28'h0000123;
        #1;
        chk("no_comb_grant", mem_req_valid, 1'b0);
        cyc();
        mem_req_ready = 1;
        #1;
        chk("rd_mreq_v", mem_req_valid, 1'b1);
        chk("rd_addr", mem_req_addr, 28'h0000123);
        chk("rd_rw", mem_req_rw, 1'b0);
        chk("rd_ic_rdy", ic_req_ready, 1'b1);
        chk("rd_dc_rdy", dc_req_ready, 1'b0);
        chk("rd_busy", busy, 1'b1);
        cyc();
        ic_req_valid = 0; mem_req_ready = 0;
        read_beats(1'b0, 0, 128'hA0);
        #1;
        chk("rd_done_busy", busy, 1'b0);

        // Tie after reset: dcache first, then icache
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        ic_req_valid = 1; ic_req_addr = 28'h300;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h200;
        cyc();
        mem_req_ready = 1;
        #1;
        chk("tie1_owner", owner, 1'b1);
        chk("tie1_addr", mem_req_addr, 28'h200);
        chk("tie1_dc_rdy", dc_req_ready, 1'b1);
        chk("tie1_ic_rdy", ic_req_ready, 1'b0);
        cyc();
        dc_req_valid = 0; mem_req_ready = 0;
        read_beats(1'b1, 0, 128'hB0);
        #1;
        chk("turn_idle", mem_req_valid, 1'b0);
        chk("turn_busy", busy, 1'b0);
        cyc();
        mem_req_ready = 1;
        #1;
        chk("tie2_owner", owner, 1'b0);
        chk("tie2_addr", mem_req_addr, 28'h300);
        cyc();
        ic_req_valid = 0; mem_req_ready = 0;
        read_beats(1'b0, 0, 128'hB8);

        // Re-raise both: back to dcache, with request backpressure and gapped beats
        ic_req_valid = 1; ic_req_addr = 28'h380;
        dc_req_valid = 1; dc_req_addr = 28'h280;
        cyc();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_mreq_v", mem_req_valid, 1'b1);
            chk("bp_addr", mem_req_addr, 28'h280);
            chk("bp_dc_rdy", dc_req_ready, 1'b0);
            cyc();
        end
        mem_req_ready = 1;
        #1;
        chk("tie3_owner", owner, 1'b1);
        chk("bp_dc_rdy_hs", dc_req_ready, 1'b1);
        cyc();
        dc_req_valid = 0; mem_req_ready = 0;
        read_beats(1'b1, 3, 128'h10);
        cyc();
        mem_req_ready = 1;
        #1;
        chk("pend_ic_owner", owner, 1'b0);
        chk("pend_ic_addr", mem_req_addr, 28'h380);
        cyc();
        ic_req_valid = 0; mem_req_ready = 0;
        read_beats(1'b0, 0, 128'h20);

        // Stray response beat while idle
        mem_resp_valid = 1; mem_resp_data = 128'hEE;
        #1;
        chk("stray_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
        cyc();
        mem_resp_valid = 0;
        #1;
        chk("stray_busy", busy, 1'b0);

        // Write-back with toggling write ready
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0000040;
        cyc();
        mem_req_ready = 1;
        #1;
        chk("wb_rw", mem_req_rw, 1'b1);
        chk("wb_addr", mem_req_addr, 28'h0000040);
        chk("wb_dc_rdy", dc_req_ready, 1'b1);
        cyc();
        dc_req_valid = 0; dc_req_rw = 0; mem_req_ready = 0;
        n = 0;
        k = 0;
        while (n < 4 && k < 20) begin
            dc_wdata_valid = 1;
            dc_wdata = 128'hD0 + 128'(n);
            dc_wdata_mask = 16'hFFFF;
            mem_wdata_ready = (k % 2) == 1;
            #1;
            chk("wb_wvalid", mem_wdata_valid, 1'b1);
            chk("wb_wready", dc_wdata_ready, mem_wdata_ready);
            chk("wb_no_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
            if (mem_wdata_valid && mem_wdata_ready) begin
                chk("wb_data", mem_wdata, 128'hD0 + 128'(n));
                chk("wb_mask", mem_wdata_mask, 16'hFFFF);
                n++;
            end
            k++;
            cyc();
        end
        chk("wb_beats", n, 4);
        mem_wdata_ready = 1;
        #1;
        chk("wb_idle", busy, 1'b0);
        chk("wb_no_ack", dc_wdata_ready, 1'b0);
        chk("wb_no_wv", mem_wdata_valid, 1'b0);
        dc_wdata_valid = 0; mem_wdata_ready = 0;
        cyc();

        // Reset in the middle of a read
        ic_req_valid = 1; ic_req_addr = 28'h500;
        cyc();
        mem_req_ready = 1;
        cyc();
        ic_req_valid = 0; mem_req_ready = 0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1; mem_resp_data = 128'h50 + 128'(i);
            #1;
            chk("mid_resp", ic_resp_valid, 1'b1);
            cyc();
        end
        mem_resp_valid = 1; mem_resp_data = 128'h52;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_resp", ic_resp_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_owner", owner, 1'b0);
        cyc();
        reset_n = 1'b1;
        mem_resp_data = 128'h53;
        #1;
        chk("post_rst_drop", {ic_resp_valid, dc_resp_valid}, 2'b00);
        cyc();
        mem_resp_valid = 0;
        ic_req_valid = 1; ic_req_addr = 28'h600;
        cyc();
        mem_req_ready = 1;
        #1;
        chk("fresh_addr", mem_req_addr, 28'h600);
        cyc();
        ic_req_valid = 0; mem_req_ready = 0;
        read_beats(1'b0, 1, 128'hC0);
        #1;
        chk("fresh_done", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
